// File: rtl/bcd_bin_conv.sv
// bcd_bin_conv
//   Converts a packed BCD word into binary, one digit per clock, most
//   significant digit first. A conversion containing any nibble above 9
//   reports err and a zero result instead of the arithmetic value.
//
// Ports
//   sys_clk   system clock, rising edge
//   rst       synchronous reset, active high
//   start     conversion request, only looked at while idle
//   bcd_data  packed BCD, top nibble is the most significant digit
//   bin_data  registered binary result, held between completions
//   busy      conversion in progress
//   done      one-cycle completion pulse
//   err       last conversion contained an invalid nibble
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; results held
// CALC  | one captured digit folded into the accumulator per cycle
module bcd_bin_conv #(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_W      = 20
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_data,
  output logic [BIN_W-1:0]        bin_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int ACC_W  = BIN_W + 4;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t             state, state_n;
  logic [DATA_W-1:0]  digits, digits_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               inv, inv_n;
  logic [BIN_W-1:0]   bin_n;
  logic               busy_n, done_n, err_n;

  logic [3:0]         nib;
  logic               nib_bad;
  logic               last;
  logic [ACC_W-1:0]   acc_step;

  assign nib      = digits[DATA_W-1 -: 4];
  assign nib_bad  = (nib > 4'd9);
  assign last     = (cnt == CNT_W'(NUM_DIGITS - 1));
  // acc*10 as two shifts; the 4 guard bits keep the product untruncated
  assign acc_step = (acc << 3) + (acc << 1) + ACC_W'(nib);

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (last)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    digits_n = digits;
    acc_n    = acc;
    cnt_n    = cnt;
    inv_n    = inv;
    bin_n    = bin_data;
    busy_n   = busy;
    err_n    = err;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          digits_n = bcd_data;
          acc_n    = '0;
          cnt_n    = '0;
          inv_n    = 1'b0;
          err_n    = 1'b0;
          busy_n   = 1'b1;
        end
      end
      CALC: begin
        digits_n = digits << 4;
        acc_n    = acc_step;
        cnt_n    = cnt + CNT_W'(1);
        inv_n    = inv | nib_bad;
        if (last) begin
          done_n = 1'b1;
          busy_n = 1'b0;
          // the current nibble counts toward validity of the result
          if (inv | nib_bad) begin
            bin_n = '0;
            err_n = 1'b1;
          end else begin
            bin_n = acc_step[BIN_W-1:0];
            err_n = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      digits   <= '0;
      acc      <= '0;
      cnt      <= '0;
      inv      <= 1'b0;
      bin_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      digits   <= digits_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      inv      <= inv_n;
      bin_data <= bin_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_bcd_bin_conv.sv
module tb_bcd_bin_conv;

  logic        sys_clk;
  logic        rst;
  logic        start;
  logic [23:0] bcd_data;
  logic [19:0] bin_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int failures;

  bcd_bin_conv #(.NUM_DIGITS(6), .BIN_W(20)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .start    (start),
    .bcd_data (bcd_data),
    .bin_data (bin_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: weighted sum of decimal digits; any nibble above 9 spoils it.
  task automatic model(input logic [23:0] b, output logic [31:0] v, output logic bad);
    int unsigned sum;
    int unsigned weight;
    int unsigned d;
    sum = 0;
    weight = 1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = (b >> (4 * i)) & 24'hF;
      if (d > 9) bad = 1'b1;
      sum += d * weight;
      weight *= 10;
    end
    v = bad ? 32'd0 : sum;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge
  // following done. restart_edge>0 pulses start (with other data) just
  // before that busy edge to show it is ignored.
  task automatic run_conv(input logic [23:0] b, input logic [31:0] exp_bin,
                          input logic exp_err, input int restart_edge, input string tag);
    start = 1'b1;
    bcd_data = b;
    @(posedge sys_clk); #1;
    start = 1'b0;
    bcd_data = 24'($urandom);
    chk({tag, ".busy_acc"}, busy, 1);
    chk({tag, ".done_acc"}, done, 0);
    chk({tag, ".err_clr"}, err, 0);
    for (int i = 1; i <= 5; i++) begin
      if (i == restart_edge) begin
        start = 1'b1;
        bcd_data = 24'h777777;
      end
      @(posedge sys_clk); #1;
      start = 1'b0;
      chk({tag, ".busy_run"}, busy, 1);
      chk({tag, ".done_run"}, done, 0);
    end
    @(posedge sys_clk); #1;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy_end"}, busy, 0);
    chk({tag, ".bin"}, bin_data, exp_bin);
    chk({tag, ".err"}, err, exp_err);
    @(posedge sys_clk); #1;
    chk({tag, ".done_once"}, done, 0);
    chk({tag, ".busy_idle"}, busy, 0);
    chk({tag, ".bin_hold"}, bin_data, exp_bin);
    chk({tag, ".err_hold"}, err, exp_err);
  endtask

  initial begin
    logic [31:0] exp_v;
    logic        exp_bad;
    logic [23:0] rb;
    int          c;
    checks = 0;
    failures = 0;

    // start asserted during reset must be ignored
    rst = 1'b1;
    start = 1'b1;
    bcd_data = 24'h123456;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.bin", bin_data, 0);
    rst = 1'b0;
    start = 1'b0;
    @(posedge sys_clk); #1;
    chk("post_rst.busy", busy, 0);

    run_conv(24'h123456, 32'h1E240, 1'b0, 0, "c123456");
    run_conv(24'h999999, 32'hF423F, 1'b0, 0, "c999999");
    run_conv(24'h000000, 32'h00000, 1'b0, 0, "c000000");
    run_conv(24'h12A456, 32'h00000, 1'b1, 0, "c12A456");
    run_conv(24'h000042, 32'h0002A, 1'b0, 0, "c000042");
    run_conv(24'h000100, 32'h00064, 1'b0, 3, "restart");

    // reset in busy cycle 4 kills the conversion with no done pulse
    start = 1'b1;
    bcd_data = 24'h654321;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("midrst.busy_before", busy, 1);
    rst = 1'b1;
    @(posedge sys_clk); #1;
    rst = 1'b0;
    chk("midrst.busy", busy, 0);
    chk("midrst.bin", bin_data, 0);
    chk("midrst.done", done, 0);
    chk("midrst.err", err, 0);
    c = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge sys_clk); #1;
      if (done === 1'b1) c++;
    end
    chk("midrst.no_done", c, 0);
    run_conv(24'h000001, 32'h00001, 1'b0, 0, "c000001");

    // start held high: back-to-back conversions every 7 cycles
    start = 1'b1;
    bcd_data = 24'h000010;
    @(posedge sys_clk); #1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge sys_clk); #1;
      chk("b2b.done", done, (k % 7 == 6) ? 1 : 0);
      chk("b2b.busy", busy, (k % 7 == 6) ? 0 : 1);
      if (k % 7 == 6) chk("b2b.bin", bin_data, 32'h0000A);
    end
    start = 1'b0;
    @(posedge sys_clk); #1;
    chk("b2b.stop_busy", busy, 0);
    chk("b2b.stop_done", done, 0);

    // random words, half of them forced to valid BCD
    for (int n = 0; n < 40; n++) begin
      rb = 24'($urandom);
      if (n % 2 == 0)
        for (int j = 0; j < 6; j++) rb[4*j +: 4] = 4'($urandom_range(0, 9));
      model(rb, exp_v, exp_bad);
      run_conv(rb, exp_v, exp_bad, (n % 5 == 0) ? 2 : 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
